// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressable data RAM with store-priority port and in-order load queue
module dmem_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LOAD_Q = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic        st_half,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_func3,
   input  logic [6:0]  ld_pd,
   input  logic [4:0]  ld_rob,
   output logic        ld_ready,
   input  logic        flush,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [6:0]  wb_pd,
   output logic [4:0]  wb_rob,
   output logic        misalign_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int QW = $clog2(LOAD_Q);
   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW+1:0] q_addr [LOAD_Q];
   logic [2:0]    q_f3 [LOAD_Q];
   logic [6:0]    q_pd [LOAD_Q];
   logic [4:0]    q_rob [LOAD_Q];
   logic [QW-1:0] wr_ptr, rd_ptr;
   logic [QW:0]   count;
   logic          rd_valid;
   logic [1:0]    rd_off;
   logic [2:0]    rd_f3;
   logic [6:0]    rd_pd;
   logic [4:0]    rd_rob;
   logic [31:0]   rd_word;
   logic          st_mis, st_ok, enq, deq, issue, ld_bad;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata, ld_fmt;
   logic          unused_addr;
   assign unused_addr = ^{st_addr[31:AW+2], ld_addr[31:AW+2]};
   assign st_mis   = st_valid && (st_half ? st_addr[0] : |st_addr[1:0]);
   assign st_ok    = st_valid && !st_mis;
   assign st_be    = st_half ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign st_wdata = st_half ? {2{st_data[15:0]}} : st_data;
   assign ld_ready = count < (QW+1)'(LOAD_Q);
   assign enq      = ld_valid && ld_ready && !flush;
   // a store owns the single RAM port, so any store cycle stalls the queue head
   assign deq      = !st_valid && count != '0;
   assign issue    = deq && !flush;
   assign ld_bad   = !((rd_f3 == 3'b010 && rd_off == 2'b00) || rd_f3 == 3'b100);
   assign ld_fmt   = rd_f3 == 3'b100 ? {24'b0, 8'(rd_word >> {rd_off, 3'b000})} :
                     ld_bad ? '0 : rd_word;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (st_ok && st_be[i]) mem[st_addr[AW+1:2]][8*i +: 8] <= st_wdata[8*i +: 8];
      if (enq) begin
         q_addr[wr_ptr] <= ld_addr[AW+1:0];
         q_f3[wr_ptr]   <= ld_func3;
         q_pd[wr_ptr]   <= ld_pd;
         q_rob[wr_ptr]  <= ld_rob;
      end
      if (issue) rd_word <= mem[q_addr[rd_ptr][AW+1:2]];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         rd_valid     <= 1'b0;
         rd_off       <= '0;
         rd_f3        <= '0;
         rd_pd        <= '0;
         rd_rob       <= '0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_pd        <= '0;
         wb_rob       <= '0;
         misalign_err <= 1'b0;
      end else begin
         wr_ptr   <= flush ? '0 : wr_ptr + QW'(enq);
         rd_ptr   <= flush ? '0 : rd_ptr + QW'(deq);
         count    <= flush ? '0 : count + (QW+1)'(enq) - (QW+1)'(deq);
         rd_valid <= issue;
         if (issue) begin
            rd_off <= q_addr[rd_ptr][1:0];
            rd_f3  <= q_f3[rd_ptr];
            rd_pd  <= q_pd[rd_ptr];
            rd_rob <= q_rob[rd_ptr];
         end
         wb_valid <= rd_valid && !flush;
         if (rd_valid && !flush) begin
            wb_data <= ld_fmt;
            wb_pd   <= rd_pd;
            wb_rob  <= rd_rob;
         end
         misalign_err <= st_mis || (rd_valid && !flush && ld_bad);
      end
   end
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed and randomized checks of dmem_unit against a byte-array/queue reference model
module tb_dmem_unit;
  localparam int LQ = 2;
  logic        clk = 0, reset = 0;
  logic        st_valid = 0, st_half = 0, ld_valid = 0, flush = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [2:0]  ld_func3 = 0;
  logic [6:0]  ld_pd = 0;
  logic [4:0]  ld_rob = 0;
  logic        ld_ready, wb_valid, misalign_err;
  logic [31:0] wb_data;
  logic [6:0]  wb_pd;
  logic [4:0]  wb_rob;
  always #5 clk = ~clk;
  dmem_unit #(.DEPTH_WORDS(1024), .LOAD_Q(LQ)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_half(st_half), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_func3(ld_func3),
    .ld_pd(ld_pd), .ld_rob(ld_rob), .ld_ready(ld_ready), .flush(flush), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_pd(wb_pd), .wb_rob(wb_rob), .misalign_err(misalign_err));
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [6:0]  pd;
    logic [4:0]  rob;
  } ld_t;
  ld_t         mq[$];
  logic [7:0]  mem [4096];
  logic        s1_v = 0, s1_err = 0;
  logic [31:0] s1_d = 0;
  logic [6:0]  s1_pd = 0;
  logic [4:0]  s1_rob = 0;
  logic        e_wbv = 0, e_err = 0, e_rdy;
  logic [31:0] e_data = 0;
  logic [6:0]  e_pd = 0;
  logic [4:0]  e_rob = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [2:0]  f3tab [8] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b000, 3'b001, 3'b011, 3'b110};
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [11:0] a;
    a = addr[11:0];
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction
  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic h);
    st_valid = v; st_addr = a; st_data = d; st_half = h;
  endtask
  task automatic set_ld(input logic v, input logic [31:0] a, input logic [2:0] f, input logic [6:0] p, input logic [4:0] r);
    ld_valid = v; ld_addr = a; ld_func3 = f; ld_pd = p; ld_rob = r;
  endtask
  task automatic idle();
    set_st(0, 0, 0, 0);
    set_ld(0, 0, 0, 0, 0);
    flush = 0;
  endtask
  task automatic tick();
    ld_t         h;
    logic        rdy, smis;
    logic [11:0] a;
    @(posedge clk);
    rdy  = mq.size() < LQ;
    smis = st_valid && (st_half ? st_addr[0] : (st_addr[1:0] != 2'b00));
    if (flush) begin
      e_wbv = 0; s1_v = 0; mq.delete(); e_err = smis;
    end else begin
      e_wbv = s1_v;
      if (s1_v) begin e_data = s1_d; e_pd = s1_pd; e_rob = s1_rob; end
      e_err = smis || (s1_v && s1_err);
      s1_v = 0;
      if (!st_valid && mq.size() != 0) begin
        h = mq.pop_front();
        s1_v = 1; s1_pd = h.pd; s1_rob = h.rob; s1_err = 0;
        if (h.f3 == 3'b010 && h.addr[1:0] == 2'b00) s1_d = word_at(h.addr);
        else if (h.f3 == 3'b100) s1_d = {24'b0, mem[h.addr[11:0]]};
        else begin s1_d = 0; s1_err = 1; end
      end
      if (ld_valid && rdy) mq.push_back('{ld_addr, ld_func3, ld_pd, ld_rob});
    end
    if (st_valid && !smis) begin
      a = st_addr[11:0];
      mem[a] = st_data[7:0];
      mem[a+1] = st_data[15:8];
      if (!st_half) begin mem[a+2] = st_data[23:16]; mem[a+3] = st_data[31:24]; end
    end
    #1;
    e_rdy = mq.size() < LQ;
    chk("wb_valid", wb_valid, e_wbv);
    if (e_wbv) begin
      chk("wb_data", wb_data, e_data);
      chk("wb_pd", wb_pd, e_pd);
      chk("wb_rob", wb_rob, e_rob);
    end
    chk("misalign_err", misalign_err, e_err);
    chk("ld_ready", ld_ready, e_rdy);
  endtask
  task automatic check_reset_outputs();
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_pd", wb_pd, 7'h0);
    chk("rst_wb_rob", wb_rob, 5'h0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    mq.delete(); s1_v = 0; e_wbv = 0; e_err = 0;
    e_data = 0; e_pd = 0; e_rob = 0;
  endtask
  initial begin
    int          k, wbcnt;
    logic        r;
    logic [31:0] w, a;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #1 reset = 1;
    #12 check_reset_outputs();
    @(negedge clk) reset = 0;
    for (int i = 0; i < 64; i++) begin
      set_st(1, 32'(4 * i), $urandom(), 0);
      tick();
    end
    idle();
    set_st(1, 32'h20, 32'hDEADBEEF, 0);
    tick();
    idle();
    set_ld(1, 32'h20, 3'b010, 7'd40, 5'd3);
    tick();
    idle();
    tick();
    tick();
    chk("t1_valid", wb_valid, 1'b1);
    chk("t1_data", wb_data, 32'hDEADBEEF);
    chk("t1_pd", wb_pd, 7'd40);
    chk("t1_rob", wb_rob, 5'd3);
    set_st(1, 32'h22, 32'h0000ABCD, 1);
    tick();
    idle();
    set_ld(1, 32'h20, 3'b010, 7'd1, 5'd1);
    tick();
    set_ld(1, 32'h23, 3'b100, 7'd2, 5'd2);
    tick();
    set_ld(1, 32'h20, 3'b100, 7'd3, 5'd3);
    tick();
    chk("sh_lw", wb_data, 32'hABCDBEEF);
    idle();
    tick();
    chk("lbu_23", wb_data, 32'h000000AB);
    tick();
    chk("lbu_20", wb_data, 32'h000000EF);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      set_st(c < 3, 32'h40 + 32'(4 * c), $urandom(), 0);
      set_ld(k < 3, 32'h40 + 32'(4 * k), 3'b010, 7'(50 + k), 5'(k));
      r = ld_ready;
      tick();
      if (r && k < 3) k++;
      if (c == 1) chk("blk_ready_low", ld_ready, 1'b0);
    end
    chk("blk_accepts", k, 3);
    idle();
    set_st(1, 32'h68, 32'h11111111, 0);
    set_ld(1, 32'h44, 3'b010, 7'd60, 5'd10);
    tick();
    set_st(1, 32'h6C, 32'h22222222, 0);
    set_ld(1, 32'h48, 3'b100, 7'd61, 5'd11);
    tick();
    idle();
    tick();
    flush = 1;
    set_st(1, 32'h60, 32'hCAFEF00D, 0);
    set_ld(1, 32'h4C, 3'b010, 7'd62, 5'd12);
    tick();
    idle();
    wbcnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wb_valid) wbcnt++;
    end
    chk("flush_nowb", wbcnt, 0);
    set_ld(1, 32'h60, 3'b010, 7'd9, 5'd9);
    tick();
    idle();
    tick();
    tick();
    chk("post_flush_valid", wb_valid, 1'b1);
    chk("post_flush_data", wb_data, 32'hCAFEF00D);
    set_ld(1, 32'h12, 3'b010, 7'd5, 5'd5);
    tick();
    idle();
    tick();
    tick();
    chk("mis_lw_valid", wb_valid, 1'b1);
    chk("mis_lw_data", wb_data, 32'h0);
    chk("mis_lw_err", misalign_err, 1'b1);
    w = word_at(32'h10);
    set_st(1, 32'h11, 32'h0000FFFF, 1);
    tick();
    chk("mis_sh_err", misalign_err, 1'b1);
    idle();
    set_ld(1, 32'h10, 3'b010, 7'd6, 5'd6);
    tick();
    idle();
    tick();
    tick();
    chk("mis_sh_nochg", wb_data, w);
    set_st(1, 32'h80, 32'h33333333, 0);
    set_ld(1, 32'h80, 3'b010, 7'd7, 5'd7);
    tick();
    set_st(1, 32'h84, 32'h44444444, 0);
    set_ld(1, 32'h84, 3'b010, 7'd8, 5'd8);
    tick();
    idle();
    #2 reset = 1;
    #1 check_reset_outputs();
    @(negedge clk) reset = 0;
    wbcnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wb_valid) wbcnt++;
    end
    chk("rst_nowb", wbcnt, 0);
    for (int c = 0; c < 2000; c++) begin
      a = ($urandom() & 32'hFFFFF0FC) | (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'h0);
      set_st($urandom_range(9) < 3, a, $urandom(), 1'($urandom_range(1)));
      a = ($urandom() & 32'hFFFFF0FC) | (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'h0);
      set_ld($urandom_range(9) < 6, a, f3tab[$urandom_range(7)], 7'($urandom()), 5'($urandom()));
      flush = $urandom_range(31) == 0;
      tick();
    end
    idle();
    for (int c = 0; c < 6; c++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
